// File: rtl/burst_mem_responder_if.sv
// rtl/burst_mem_responder_if.sv - ReadRequest/DataReady burst bus between fetch unit and memory model
//
// Purpose: bundles the request and response signals of the burst read bus.
//   master modport: fetch/prefetch side (drives request, address, flush)
//   slave  modport: memory side (drives busy, data, ready, word index, last)
// Signals:
//   ReadRequest_i  request strobe
//   ReadAddress_i  byte address of the requested word
//   Flush_i        abort the current burst
//   ReadBusy_o     burst in progress
//   DataOut_o      word data, valid with DataReady_o
//   DataReady_o    one-cycle pulse per delivered word
//   WordIndex_o    word offset of DataOut_o within the block
//   LastWord_o     final word of the burst
interface burst_mem_responder_if #(
  parameter int unsigned BLOCK_WORDS = 4
);
  localparam int unsigned OFS_W = $clog2(BLOCK_WORDS);

  logic              ReadRequest_i;
  logic [31:0]       ReadAddress_i;
  logic              Flush_i;
  logic              ReadBusy_o;
  logic [31:0]       DataOut_o;
  logic              DataReady_o;
  logic [OFS_W-1:0]  WordIndex_o;
  logic              LastWord_o;

  modport master (
    output ReadRequest_i, ReadAddress_i, Flush_i,
    input  ReadBusy_o, DataOut_o, DataReady_o, WordIndex_o, LastWord_o
  );

  modport slave (
    input  ReadRequest_i, ReadAddress_i, Flush_i,
    output ReadBusy_o, DataOut_o, DataReady_o, WordIndex_o, LastWord_o
  );
endinterface

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - instruction-side burst read memory model
//
// Purpose: answers one block-read request at a time. After FIRST_DELAY cycles
// it delivers BLOCK_WORDS words, one DataReady_o pulse each, NEXT_DELAY cycles
// apart. Addresses outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS) read as zero.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-low reset (array contents are kept)
//   bus    burst_mem_responder_if.slave (request in, word stream out)
// Optional feature macro: BURST_CRITICAL_WORD_FIRST_EN
//   defined   - burst starts at the requested word and wraps within the block
//   undefined - burst always starts at word 0 of the block
// The array mem has no write port; its contents are preloaded hierarchically.
module burst_mem_responder #(
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned FIRST_DELAY = 10,
  parameter int unsigned NEXT_DELAY  = 1,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h00010000
) (
  input  logic                 clk,
  input  logic                 reset,
  burst_mem_responder_if.slave bus
);
  localparam int unsigned OFS_W   = $clog2(BLOCK_WORDS);
  localparam int unsigned CNT_MAX = (FIRST_DELAY > NEXT_DELAY) ? FIRST_DELAY : NEXT_DELAY;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [CNT_W-1:0] FIRST_LOAD = CNT_W'(FIRST_DELAY - 1);
  localparam logic [CNT_W-1:0] NEXT_LOAD  = CNT_W'(NEXT_DELAY - 1);
  localparam logic [OFS_W-1:0] LAST_NUM   = OFS_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

  logic [31:0] mem [MEM_WORDS];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      base_q, base_d;
  logic [OFS_W-1:0] ofs_q, ofs_d;    // offset of the word being delivered
  logic [OFS_W-1:0] num_q, num_d;    // words already delivered in this burst
  logic             busy_q;
  logic [OFS_W-1:0] start_ofs;
  logic             last_word;
  logic             sending;
  logic [31:0]      word_addr;
  logic [29:0]      word_off;
  logic             in_range;
  logic             unused_addr;

`ifdef BURST_CRITICAL_WORD_FIRST_EN
  assign start_ofs = bus.ReadAddress_i[OFS_W+1:2];
`else
  assign start_ofs = '0;
`endif
  // Byte-lane bits (and the offset bits in the ascending build) carry no meaning here.
  assign unused_addr = ^bus.ReadAddress_i[OFS_W+1:0];

  assign last_word = (num_q == LAST_NUM);
  assign sending   = (state_q == S_SEND);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      ofs_q   <= '0;
      num_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      ofs_q   <= ofs_d;
      num_q   <= num_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // The counter holds the number of WAIT cycles still to come; a delay of 1
  // skips WAIT entirely so SEND follows the accepting/previous edge directly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    ofs_d   = ofs_q;
    num_d   = num_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ReadRequest_i && !bus.Flush_i) begin
          base_d  = {bus.ReadAddress_i[31:OFS_W+2], {(OFS_W+2){1'b0}}};
          ofs_d   = start_ofs;
          num_d   = '0;
          cnt_d   = FIRST_LOAD;
          state_d = (FIRST_DELAY == 1) ? S_SEND : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.Flush_i) begin
          state_d = S_IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SEND: begin
        if (bus.Flush_i || last_word) begin
          state_d = S_IDLE;
        end else begin
          ofs_d   = ofs_q + OFS_W'(1);
          num_d   = num_q + OFS_W'(1);
          cnt_d   = NEXT_LOAD;
          state_d = (NEXT_DELAY == 1) ? S_SEND : S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign word_addr = base_q | {{(30-OFS_W){1'b0}}, ofs_q, 2'b00};
  assign word_off  = word_addr[31:2] - BASE_ADDR[31:2];
  assign in_range  = (word_addr >= BASE_ADDR) && ({2'b00, word_off} < 32'(MEM_WORDS));

  assign bus.ReadBusy_o  = busy_q;
  assign bus.DataReady_o = sending;
  assign bus.DataOut_o   = (sending && in_range) ? mem[word_off[IDX_W-1:0]] : 32'h0;
  assign bus.WordIndex_o = sending ? ofs_q : '0;
  assign bus.LastWord_o  = sending && last_word;
endmodule
